slow_spi_master: RTL and testbench



---
 rtl/slow_spi_master_if.sv | 25 ++
 rtl/slow_spi_master.sv | 136 +++++++++++++
 tb/tb_slow_spi_master.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slow_spi_master_if.sv
// Host-side handshake and SPI pin bundle for slow_spi_master.
// The master modport is the environment (host plus attached ASIC); slave is the engine.
interface slow_spi_master_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] tx_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rx_data;
    logic             sclk;
    logic             cs_n;
    logic             mosi;
    logic             miso;

    modport master (
        output start, tx_data, miso,
        input  busy, done, rx_data, sclk, cs_n, mosi
    );

    modport slave (
        input  start, tx_data, miso,
        output busy, done, rx_data, sclk, cs_n, mosi
    );
endinterface

// File: rtl/slow_spi_master.sv
// Mode-0 SPI master with half-period tick timing (H = DIV+1 clk cycles per SCLK phase).
// Optional SLOW_SPI_LOOPBACK_EN: receive path samples internal mosi instead of the miso pin.
module slow_spi_master #(
    parameter int WIDTH = 16,
    parameter int DIV   = 625
) (
    input  logic              clk,
    input  logic              rst_n,
    slow_spi_master_if.slave  bus
);
    localparam int CW = (DIV < 1) ? 1 : $clog2(DIV + 1);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] DIV_C   = CW'(DIV);
    localparam logic [BW-1:0] WIDTH_C = BW'(WIDTH);
    localparam logic [BW-1:0] LAST_C  = BW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    falls_q, falls_d;
    logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             sclk_q, sclk_d;
    logic             cs_n_q, cs_n_d;
    logic             mosi_q, mosi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick;
    logic             sample_bit;

`ifdef SLOW_SPI_LOOPBACK_EN
    assign sample_bit = mosi_q;
`else
    assign sample_bit = bus.miso;
`endif

    assign tick = (state_q != IDLE) && (cnt_q == DIV_C);

    always_comb begin
        state_d   = state_q;
        cnt_d     = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
        falls_d   = falls_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tx_sh_d = bus.tx_data;
                    rx_sh_d = '0;
                    falls_d = '0;
                    mosi_d  = bus.tx_data[WIDTH-1];
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = LEAD;
                end
            end
            LEAD: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    rx_sh_d = {rx_sh_q[WIDTH-2:0], sample_bit};
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d  = 1'b0;
                        falls_d = falls_q + 1'b1;
                        tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
                        mosi_d  = (falls_q == LAST_C) ? 1'b0 : tx_sh_q[WIDTH-2];
                    end else if (falls_q == WIDTH_C) begin
                        // Low half-period after the last fall ends here instead of rising again.
                        state_d = TRAIL;
                    end else begin
                        sclk_d  = 1'b1;
                        rx_sh_d = {rx_sh_q[WIDTH-2:0], sample_bit};
                    end
                end
            end
            TRAIL: begin
                if (tick) begin
                    state_d   = IDLE;
                    cs_n_d    = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    mosi_d    = 1'b0;
                    rx_data_d = rx_sh_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            falls_q   <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            falls_q   <= falls_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
    assign bus.sclk    = sclk_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.mosi    = mosi_q;
endmodule

// File: tb/tb_slow_spi_master.sv
// Bench for slow_spi_master: a SPI slave model plus frame timing derived from H and WIDTH.
// Instance A: WIDTH=16, DIV=3. Instance B: WIDTH=16, DIV=0 (loopback expectation follows the macro).
module tb_slow_spi_master;
    localparam int W      = 16;
    localparam int HA     = 4;
    localparam int XFER_A = (2 * W + 2) * HA;
    localparam int XFER_B = (2 * W + 2) * 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    slow_spi_master_if #(.WIDTH(W)) ifa ();
    slow_spi_master_if #(.WIDTH(W)) ifb ();

    slow_spi_master #(.WIDTH(W), .DIV(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    slow_spi_master #(.WIDTH(W), .DIV(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [W-1:0] slave_word = '0;
    logic [W-1:0] mosi_bits = '0;
    int idx = 0;
    int rises = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int cs_run = 0;
    int last_cs_run = -1;
    int rise_cyc[$];
    logic prev_sclk = 1'b0;

    // Slave model: counts edges, captures mosi on each rise, shifts miso after each fall.
    initial begin
        ifa.miso = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst_n || ifa.cs_n) begin
                idx = 0;
                prev_sclk = 1'b0;
            end else begin
                if (!prev_sclk && ifa.sclk) begin
                    rises++;
                    rise_cyc.push_back(cyc);
                    mosi_bits = {mosi_bits[W-2:0], ifa.mosi};
                end
                if (prev_sclk && !ifa.sclk) idx++;
                prev_sclk = ifa.sclk;
            end
            ifa.miso = (idx < W) ? slave_word[W-1-idx] : 1'b0;
            if (ifa.busy) busy_cnt++;
            if (ifa.done) done_cnt++;
            if (ifa.cs_n) cs_run++;
            else if (cs_run > 0) begin
                last_cs_run = cs_run;
                cs_run = 0;
            end
        end
    end

    task automatic clear_stats();
        rises = 0;
        rise_cyc.delete();
        mosi_bits = '0;
        busy_cnt = 0;
        done_cnt = 0;
        last_cs_run = -1;
    endtask

    task automatic launch(input logic [W-1:0] tx, input logic [W-1:0] word, output int k);
        slave_word = word;
        clear_stats();
        ifa.tx_data = tx;
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        k = cyc;
        $display("launch tx=%h slave_word=%h at edge %0d", tx, word, k);
    endtask

    task automatic wait_done(output int t);
        t = -1;
        for (int i = 0; i < 400; i++) begin
            if (ifa.done) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_xfer(input string name, input logic [W-1:0] tx, input logic [W-1:0] word,
                              input int k, input int t);
        int first;
        int bad;
        first = (rise_cyc.size() > 0) ? rise_cyc[0] : -1;
        bad = 0;
        for (int i = 1; i < rise_cyc.size(); i++)
            if (rise_cyc[i] - rise_cyc[i-1] != 2 * HA) bad++;
        checks++;
        if (t != k + XFER_A) begin
            failures++;
            $display("FAIL %s done_edge: got %0d want %0d", name, t, k + XFER_A);
        end
        checks++;
        if (busy_cnt != XFER_A) begin
            failures++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, XFER_A);
        end
        checks++;
        if (rises != W) begin
            failures++;
            $display("FAIL %s sclk_rises: got %0d want %0d", name, rises, W);
        end
        checks++;
        if (first != k + HA) begin
            failures++;
            $display("FAIL %s first_rise: got %0d want %0d", name, first, k + HA);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s rise_spacing: got %0d bad gaps want 0", name, bad);
        end
        checks++;
        if (mosi_bits !== tx) begin
            failures++;
            $display("FAIL %s mosi_word: got %h want %h", name, mosi_bits, tx);
        end
        checks++;
        if (ifa.rx_data !== word) begin
            failures++;
            $display("FAIL %s rx_data: got %h want %h", name, ifa.rx_data, word);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL %s done_count: got %0d want 1", name, done_cnt);
        end
        checks++;
        if ({ifa.cs_n, ifa.busy, ifa.mosi, ifa.sclk} !== 4'b1000) begin
            failures++;
            $display("FAIL %s end_pins cs_n/busy/mosi/sclk: got %b want 1000", name,
                     {ifa.cs_n, ifa.busy, ifa.mosi, ifa.sclk});
        end
        $display("xfer %s tx=%h rx=%h done_edge=%0d", name, tx, ifa.rx_data, t);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifa.start = 1'b0;
        ifa.tx_data = '0;
        ifb.start = 1'b0;
        ifb.tx_data = '0;
        ifb.miso = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if ({ifa.busy, ifa.done, ifa.rx_data, ifa.sclk, ifa.cs_n, ifa.mosi} !==
                {1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL reset_idle cycle %0d: got busy=%b done=%b rx=%h sclk=%b cs_n=%b mosi=%b want 0 0 0000 0 1 0",
                         i, ifa.busy, ifa.done, ifa.rx_data, ifa.sclk, ifa.cs_n, ifa.mosi);
            end
        end
        $display("reset idle window checked");
    endtask

    task automatic test_single();
        int k, t;
        launch(16'hA5C3, 16'h3C5A, k);
        wait_done(t);
        check_xfer("single", 16'hA5C3, 16'h3C5A, k, t);
        @(negedge clk);
        checks++;
        if (ifa.done !== 1'b0) begin
            failures++;
            $display("FAIL single done_pulse_width: got done=%b want 0", ifa.done);
        end
    endtask

    task automatic test_back_to_back();
        int k, t;
        launch(16'h1234, 16'hBEEF, k);
        wait_done(t);
        check_xfer("b2b_first", 16'h1234, 16'hBEEF, k, t);
        launch(16'h0001, 16'h8001, k);
        wait_done(t);
        check_xfer("b2b_second", 16'h0001, 16'h8001, k, t);
        checks++;
        if (last_cs_run != 1) begin
            failures++;
            $display("FAIL b2b cs_n_high_gap: got %0d want 1", last_cs_run);
        end
    endtask

    task automatic test_ignored_start();
        int k, t;
        logic [W-1:0] tx, word;
        tx = W'($urandom);
        word = W'($urandom) | 16'h8001;
        launch(tx, word, k);
        while (cyc < k + 40) @(negedge clk);
        ifa.tx_data = ~tx;
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        wait_done(t);
        check_xfer("ignored_start", tx, word, k, t);
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL ignored_start late_done_count: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_abort();
        int k, t;
        logic [W-1:0] tx, word;
        tx = W'($urandom);
        word = W'($urandom);
        launch(tx, word, k);
        while (cyc < k + 70) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({ifa.cs_n, ifa.sclk, ifa.busy, ifa.done, ifa.mosi, ifa.rx_data} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
            failures++;
            $display("FAIL abort pins: got cs_n=%b sclk=%b busy=%b done=%b mosi=%b rx=%h want 1 0 0 0 0 0000",
                     ifa.cs_n, ifa.sclk, ifa.busy, ifa.done, ifa.mosi, ifa.rx_data);
        end
        rst_n = 1'b1;
        repeat (XFER_A) @(negedge clk);
        checks++;
        if (done_cnt != 0) begin
            failures++;
            $display("FAIL abort spurious_done: got %0d want 0", done_cnt);
        end
        $display("abort at edge %0d handled", k + 70);
        tx = W'($urandom);
        word = W'($urandom);
        launch(tx, word, k);
        wait_done(t);
        check_xfer("after_abort", tx, word, k, t);
    endtask

    task automatic test_random();
        int k, t;
        logic [W-1:0] tx, word;
        for (int n = 0; n < 4; n++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            tx = W'($urandom);
            word = W'($urandom);
            launch(tx, word, k);
            wait_done(t);
            check_xfer("random", tx, word, k, t);
        end
    endtask

    task automatic test_div0_loopback();
        int cnt;
        bit seen;
        logic [W-1:0] want;
`ifdef SLOW_SPI_LOOPBACK_EN
        want = 16'hFFFE;
`else
        want = 16'h0000;
`endif
        cnt = 0;
        seen = 1'b0;
        ifb.miso = 1'b0;
        ifb.tx_data = 16'hFFFE;
        ifb.start = 1'b1;
        @(negedge clk);
        ifb.start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ifb.done) begin
                seen = 1'b1;
                break;
            end
            if (ifb.busy) cnt++;
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL div0 done_seen: got 0 want 1");
        end
        checks++;
        if (cnt != XFER_B) begin
            failures++;
            $display("FAIL div0 busy_cycles: got %0d want %0d", cnt, XFER_B);
        end
        checks++;
        if (ifb.rx_data !== want) begin
            failures++;
            $display("FAIL div0 rx_data: got %h want %h", ifb.rx_data, want);
        end
        $display("xfer div0 tx=fffe rx=%h busy_cycles=%0d", ifb.rx_data, cnt);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignored_start();
        test_abort();
        test_random();
        test_div0_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
